// File: rtl/id_ex_hazard_if.sv
// Pipeline sequencing bundle between the hazard controller and the IF/ID, ID/EX, PC registers.
// HAZARD_PERF_CNT_EN adds the stall_cycles performance counter output.
interface id_ex_hazard_if #(
    parameter int unsigned REG_ID_WIDTH = 5
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH    = 32
`endif
);
    logic                    id_valid;
    logic [REG_ID_WIDTH-1:0] id_rs1;
    logic [REG_ID_WIDTH-1:0] id_rs2;
    logic                    id_uses_rs1;
    logic                    id_uses_rs2;
    logic [REG_ID_WIDTH-1:0] ex_dest;
    logic                    ex_mem_read;
    logic                    ex_reg_write;
    logic                    redirect;
    logic                    mem_busy;
    logic                    fetch_busy;

    logic                    pc_write_en;
    logic                    if_id_write_en;
    logic                    id_ex_write_en;
    logic                    id_ex_bubble;
    logic                    if_id_flush;
    logic                    id_ex_flush;
    logic [1:0]              ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0]    stall_cycles;
`endif

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_dest, ex_mem_read, ex_reg_write, redirect, mem_busy, fetch_busy,
        input  pc_write_en, if_id_write_en, id_ex_write_en, id_ex_bubble,
        input  if_id_flush, id_ex_flush, ctrl_state
`ifdef HAZARD_PERF_CNT_EN
        ,
        input  stall_cycles
`endif
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_dest, ex_mem_read, ex_reg_write, redirect, mem_busy, fetch_busy,
        output pc_write_en, if_id_write_en, id_ex_write_en, id_ex_bubble,
        output if_id_flush, id_ex_flush, ctrl_state
`ifdef HAZARD_PERF_CNT_EN
        ,
        output stall_cycles
`endif
    );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use / memory-freeze / redirect-squash sequencing for the IF/ID and ID/EX registers and PC.
// HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter.
module id_ex_hazard_ctrl #(
    parameter int unsigned REG_ID_WIDTH = 5,
    parameter int unsigned FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH    = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    id_ex_hazard_if.slave   bus
);
    localparam int unsigned     FCNT_W      = 3;
    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam bit              MULTI_FLUSH = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

    logic [REG_ID_WIDTH-1:0] rs1, rs2, dest;
    logic hz;
    logic pc_we, ifid_we, idex_we, bubble, ifid_fl, idex_fl;

    assign rs1  = bus.id_rs1;
    assign rs2  = bus.id_rs2;
    assign dest = bus.ex_dest;

    // Load in EX writing a register the ID instruction reads; x0 never hazards.
    assign hz = bus.id_valid & bus.ex_mem_read & bus.ex_reg_write & (dest != '0) &
                ((bus.id_uses_rs1 & (rs1 == dest)) | (bus.id_uses_rs2 & (rs2 == dest)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next state and pipeline controls; priority mem_busy > redirect > hz > fetch_busy.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_we = 1'b0;
        bubble  = 1'b0;
        ifid_fl = 1'b0;
        idex_fl = 1'b0;
        unique case (state_q)
            RUN, LOAD_STALL, MEM_WAIT: begin
                if (bus.mem_busy) begin
                    state_d = MEM_WAIT;
                end else if (bus.redirect) begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                    if (MULTI_FLUSH) begin
                        fcnt_d  = FLUSH_RELOAD;
                        state_d = FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q != LOAD_STALL && (hz || bus.fetch_busy)) begin
                    idex_we = 1'b1;
                    bubble  = 1'b1;
                    state_d = hz ? LOAD_STALL : RUN;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (!bus.mem_busy) begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                    if (bus.redirect) begin
                        fcnt_d = FLUSH_RELOAD;
                    end else begin
                        fcnt_d = fcnt_q - FCNT_W'(1);
                        if (fcnt_q <= FCNT_W'(1)) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Reset forces every control low independent of the inputs.
    assign bus.pc_write_en    = reset & pc_we;
    assign bus.if_id_write_en = reset & ifid_we;
    assign bus.id_ex_write_en = reset & idex_we;
    assign bus.id_ex_bubble   = reset & bubble;
    assign bus.if_id_flush    = reset & ifid_fl;
    assign bus.id_ex_flush    = reset & idex_fl;
    assign bus.ctrl_state     = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (!pc_we && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end

    assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl (FLUSH_CYCLES=3); covers HAZARD_PERF_CNT_EN when defined.
module tb_id_ex_hazard_ctrl;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef HAZARD_PERF_CNT_EN
    id_ex_hazard_if #(.REG_ID_WIDTH(5), .CNT_WIDTH(4)) bus ();
    id_ex_hazard_ctrl #(.REG_ID_WIDTH(5), .FLUSH_CYCLES(3), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
`else
    id_ex_hazard_if #(.REG_ID_WIDTH(5)) bus ();
    id_ex_hazard_ctrl #(.REG_ID_WIDTH(5), .FLUSH_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_we, if_id_we, id_ex_we, bubble, if_id_flush, id_ex_flush, state[1:0]}
    function automatic logic [7:0] outs();
        return {bus.pc_write_en, bus.if_id_write_en, bus.id_ex_write_en, bus.id_ex_bubble,
                bus.if_id_flush, bus.id_ex_flush, bus.ctrl_state};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_rs1       = 5'd0;
        bus.id_rs2       = 5'd0;
        bus.id_uses_rs1  = 1'b0;
        bus.id_uses_rs2  = 1'b0;
        bus.ex_dest      = 5'd0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_reg_write = 1'b0;
        bus.redirect     = 1'b0;
        bus.mem_busy     = 1'b0;
        bus.fetch_busy   = 1'b0;
    endtask

    task automatic set_hz();
        bus.id_valid     = 1'b1;
        bus.id_rs1       = 5'd5;
        bus.id_uses_rs1  = 1'b1;
        bus.ex_dest      = 5'd5;
        bus.ex_mem_read  = 1'b1;
        bus.ex_reg_write = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // Reset: outputs low even with hazard and redirect present
        idle();
        set_hz();
        bus.redirect = 1'b1;
        reset = 1'b0;
        #1 chk("reset_outs", 32'(outs()), 32'h00);
        step();
        reset = 1'b1;
        idle();
        #1 chk("run_idle", 32'(outs()), 32'hE0);

        // Load-use stall on rs1
        step(); set_hz();
        #1 chk("lu_stall", 32'(outs()), 32'h30);
        step();
        #1 chk("lu_load_stall", 32'(outs()), 32'hE1);
        step(); bus.ex_mem_read = 1'b0;
        #1 chk("lu_back_run", 32'(outs()), 32'hE0);

        // No stall for x0 destination or unused rs1
        step(); set_hz(); bus.ex_dest = 5'd0; bus.id_rs1 = 5'd0;
        #1 chk("x0_no_stall", 32'(outs()), 32'hE0);
        step(); set_hz(); bus.id_uses_rs1 = 1'b0;
        #1 chk("unused_rs1", 32'(outs()), 32'hE0);
        step(); bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
        #1 chk("lu_rs2_stall", 32'(outs()), 32'h30);
        step(); idle();
        #1 chk("lu_rs2_masked", 32'(outs()), 32'hE1);

        // Fetch busy: bubble without leaving RUN
        step(); bus.fetch_busy = 1'b1;
        #1 chk("fetch_bubble", 32'(outs()), 32'h30);
        step(); bus.fetch_busy = 1'b0;
        #1 chk("fetch_stays_run", 32'(outs()), 32'hE0);

        // Redirect with hazard present: flush wins, three flush cycles
        step(); set_hz(); bus.redirect = 1'b1;
        #1 chk("redir_run", 32'(outs()), 32'hEC);
        step(); idle();
        #1 chk("redir_flush1", 32'(outs()), 32'hEF);
        step();
        #1 chk("redir_flush2", 32'(outs()), 32'hEF);
        step();
        #1 chk("redir_done", 32'(outs()), 32'hE0);

        // mem_busy during FLUSH freezes and holds the counter
        step(); bus.redirect = 1'b1;
        #1 chk("redir2_run", 32'(outs()), 32'hEC);
        step(); bus.redirect = 1'b0; bus.mem_busy = 1'b1;
        #1 chk("flush_frozen", 32'(outs()), 32'h03);
        step(); bus.mem_busy = 1'b0;
        #1 chk("flush_resume1", 32'(outs()), 32'hEF);
        step();
        #1 chk("flush_resume2", 32'(outs()), 32'hEF);
        step();
        #1 chk("flush_resume_done", 32'(outs()), 32'hE0);

        // mem_busy 4 cycles with hazard, zero-cycle restart into a stall
        step(); set_hz(); bus.mem_busy = 1'b1;
        #1 chk("mb_first", 32'(outs()), 32'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            #1 chk("mb_wait", 32'(outs()), 32'h02);
        end
        step(); bus.mem_busy = 1'b0;
        #1 chk("mb_restart_hz", 32'(outs()), 32'h32);
        step();
        #1 chk("mb_load_stall", 32'(outs()), 32'hE1);
        step(); idle();
        #1 chk("mb_run", 32'(outs()), 32'hE0);

        // Redirect held through a freeze, taken on restart
        step(); bus.redirect = 1'b1; bus.mem_busy = 1'b1;
        #1 chk("mbr_first", 32'(outs()), 32'h00);
        step();
        #1 chk("mbr_wait", 32'(outs()), 32'h02);
        step(); bus.mem_busy = 1'b0;
        #1 chk("mbr_restart", 32'(outs()), 32'hEE);
        step(); bus.redirect = 1'b0;
        #1 chk("mbr_flush1", 32'(outs()), 32'hEF);
        step();
        #1 chk("mbr_flush2", 32'(outs()), 32'hEF);
        step();
        #1 chk("mbr_done", 32'(outs()), 32'hE0);

        // Asynchronous reset mid-cycle in MEM_WAIT
        step(); bus.mem_busy = 1'b1;
        #1 chk("ar_busy", 32'(outs()), 32'h00);
        step();
        #1 chk("ar_wait", 32'(outs()), 32'h02);
        #3 reset = 1'b0;
        #1 chk("ar_reset", 32'(outs()), 32'h00);
        step(); reset = 1'b1; bus.mem_busy = 1'b0;
        #1 chk("ar_release", 32'(outs()), 32'hE0);

`ifdef HAZARD_PERF_CNT_EN
        // Saturating stall counter
        step(); reset = 1'b0;
        #1 chk("cnt_reset", 32'(bus.stall_cycles), 32'd0);
        step(); reset = 1'b1; bus.fetch_busy = 1'b1;
        repeat (20) step();
        #1 chk("cnt_saturate", 32'(bus.stall_cycles), 32'd15);
        bus.fetch_busy = 1'b0;
        reset = 1'b0;
        #1 chk("cnt_cleared", 32'(bus.stall_cycles), 32'd0);
        step(); reset = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
